// File: rtl/prpg_pkg.sv
// Shared types and the Galois LFSR step function for the PRPG pattern engine.
package prpg_pkg;

    localparam int PRPG_MAX_W = 64;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_TAP  = 4'd1,
        OP_SEED = 4'd2,
        OP_RUN  = 4'd3,
        OP_CLR  = 4'd4,
        OP_HALT = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Bits at or above w are ignored on input and returned as zero.
    function automatic logic [PRPG_MAX_W-1:0] lfsr_next(
        input logic [PRPG_MAX_W-1:0] q,
        input logic [PRPG_MAX_W-1:0] tap,
        input int unsigned           w
    );
        logic                  msb;
        logic [PRPG_MAX_W-1:0] n;
        msb = q[w-1];
        n   = '0;
        for (int i = 0; i < PRPG_MAX_W; i++) begin
            if (i == 0)
                n[0] = msb;
            else if (i < int'(w))
                n[i] = q[i-1] ^ (tap[i] & msb);
        end
        return n;
    endfunction

endpackage

// File: rtl/prpg_hd_popcount.sv
// Hamming distance between two patterns: XOR followed by a population count.
module prpg_hd_popcount #(
    parameter int WIDTH = 8,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [HD_W-1:0]  cnt
);

    logic [WIDTH-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt = cnt + HD_W'(diff[i]);
    end

endmodule

// File: rtl/prpg_lfsr_engine.sv
// Command-driven Galois LFSR pattern engine streaming RUN-length bursts over valid/ready.
// Define PRPG_HD_STATS_EN to build the Hamming-distance statistics (hd_last, hd_sum, pat_total).
module prpg_lfsr_engine
    import prpg_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter int              CNT_W    = 8,
    parameter int              SUM_W    = 16,
    parameter logic [WIDTH-1:0] TAP_RST  = 8'h1C,
    parameter logic [WIDTH-1:0] SEED_RST = 8'h01,
    localparam int             ARG_W    = (WIDTH > CNT_W) ? WIDTH : CNT_W,
    localparam int             HD_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    output logic             pat_last,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             busy,
    output logic             halted,
    output logic             zero_lock,
    output logic [HD_W-1:0]  hd_last,
    output logic [SUM_W-1:0] hd_sum,
    output logic [SUM_W-1:0] pat_total
);

    state_e           state_q, state_d;
    op_e              op;
    logic [WIDTH-1:0] tap_q;
    logic [CNT_W-1:0] remaining_q;
    logic             cmd_fire, pat_fire;

    assign op        = op_e'(cmd_op);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign pat_fire  = pat_valid & pat_ready;
    assign pat_data  = WIDTH'(lfsr_next(PRPG_MAX_W'(lfsr_q), PRPG_MAX_W'(tap_q), WIDTH));
    assign pat_last  = pat_valid && (remaining_q == CNT_W'(1));
    assign busy      = (state_q == RUN);
    assign halted    = (state_q == HALT);
    assign zero_lock = (lfsr_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        pat_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && op == OP_RUN && cmd_arg[CNT_W-1:0] != '0)
                    state_d = RUN;
                else if (cmd_valid && op == OP_HALT)
                    state_d = HALT;
            end
            RUN: begin
                pat_valid = 1'b1;
                if (pat_ready && remaining_q == CNT_W'(1))
                    state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= SEED_RST;
            tap_q       <= TAP_RST;
            remaining_q <= '0;
        end else if (cmd_fire) begin
            case (op)
                OP_TAP:  tap_q       <= cmd_arg[WIDTH-1:0];
                OP_SEED: lfsr_q      <= cmd_arg[WIDTH-1:0];
                OP_RUN:  remaining_q <= cmd_arg[CNT_W-1:0];
                default: ;
            endcase
        end else if (pat_fire) begin
            lfsr_q      <= pat_data;
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

`ifdef PRPG_HD_STATS_EN
    logic [HD_W-1:0] hd_cnt;

    function automatic logic [SUM_W-1:0] sat_add(
        input logic [SUM_W-1:0] a,
        input logic [SUM_W-1:0] b
    );
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    prpg_hd_popcount #(
        .WIDTH (WIDTH),
        .HD_W  (HD_W)
    ) u_hd_popcount (
        .a   (lfsr_q),
        .b   (pat_data),
        .cnt (hd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_last   <= '0;
            hd_sum    <= '0;
            pat_total <= '0;
        end else if (cmd_fire && op == OP_CLR) begin
            hd_last   <= '0;
            hd_sum    <= '0;
            pat_total <= '0;
        end else if (pat_fire) begin
            hd_last   <= hd_cnt;
            hd_sum    <= sat_add(hd_sum, SUM_W'(hd_cnt));
            pat_total <= sat_add(pat_total, SUM_W'(1));
        end
    end
`else
    assign hd_last   = '0;
    assign hd_sum    = '0;
    assign pat_total = '0;
`endif

endmodule
